// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator. Coordinates go out to the pixel source and
// the sync/blank decode is delayed so every output lines up with the returned pixel.
module vga_timing_gen #(
    parameter int H_DATA  = 640,
    parameter int H_FP    = 16,
    parameter int H_PW    = 96,
    parameter int H_BP    = 48,
    parameter int V_DATA  = 480,
    parameter int V_FP    = 10,
    parameter int V_PW    = 2,
    parameter int V_BP    = 33,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int PX_LAT  = 2,
    parameter int COLOR_W = 4
) (
    input  logic                   px_clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [3*COLOR_W-1:0]   px_data,
    output logic [10:0]            px_h,
    output logic [10:0]            px_v,
    output logic                   px_req,
    output logic [COLOR_W-1:0]     RED,
    output logic [COLOR_W-1:0]     GRN,
    output logic [COLOR_W-1:0]     BLU,
    output logic                   HSYNC,
    output logic                   VSYNC,
    output logic                   de,
    output logic                   line_start,
    output logic                   frame_start
);

    localparam int H_TOTAL = H_DATA + H_FP + H_PW + H_BP;
    localparam int V_TOTAL = V_DATA + V_FP + V_PW + V_BP;
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    // 12-bit bounds so a sync pulse ending exactly at 2048 does not wrap to 0
    localparam logic [11:0] H_ACT  = 12'(H_DATA);
    localparam logic [11:0] HS_BEG = 12'(H_DATA + H_FP);
    localparam logic [11:0] HS_END = 12'(H_DATA + H_FP + H_PW);
    localparam logic [11:0] V_ACT  = 12'(V_DATA);
    localparam logic [11:0] VS_BEG = 12'(V_DATA + V_FP);
    localparam logic [11:0] VS_END = 12'(V_DATA + V_FP + V_PW);
    localparam logic HS_IDLE = ~HS_POL;
    localparam logic VS_IDLE = ~VS_POL;

    typedef struct packed {
        logic act;
        logic hs_act;
        logic vs_act;
        logic org_h;
        logic org_f;
    } dec_t;

    logic [10:0]          r_h;
    logic [10:0]          r_v;
    logic [11:0]          w_h12;
    logic [11:0]          w_v12;
    dec_t                 w_dec;
    dec_t                 w_tail;
    logic [3*COLOR_W-1:0] r_rgb;
    logic                 r_de;
    logic                 r_hs;
    logic                 r_vs;
    logic                 r_ls;
    logic                 r_fs;

    // Raster counters: h wraps each line, v steps on h wrap and wraps each frame
    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            r_h <= 11'd0;
            r_v <= 11'd0;
        end else if (en) begin
            if (r_h == H_LAST) begin
                r_h <= 11'd0;
                if (r_v == V_LAST) begin
                    r_v <= 11'd0;
                end else begin
                    r_v <= r_v + 11'd1;
                end
            end else begin
                r_h <= r_h + 11'd1;
            end
        end
    end

    assign w_h12 = {1'b0, r_h};
    assign w_v12 = {1'b0, r_v};

    // Per-coordinate decode of active area, sync windows and origin markers
    always_comb begin
        w_dec        = '0;
        w_dec.act    = (w_h12 < H_ACT) && (w_v12 < V_ACT);
        w_dec.hs_act = (w_h12 >= HS_BEG) && (w_h12 < HS_END);
        w_dec.vs_act = (w_v12 >= VS_BEG) && (w_v12 < VS_END);
        w_dec.org_h  = (r_h == 11'd0);
        w_dec.org_f  = (r_h == 11'd0) && (r_v == 11'd0);
    end

    assign px_h   = r_h;
    assign px_v   = r_v;
    assign px_req = en & w_dec.act;

    generate
        if (PX_LAT == 0) begin : g_nopipe
            assign w_tail = w_dec;
        end else begin : g_pipe
            dec_t r_pipe [PX_LAT];

            // Delay line matching the pixel source read latency; resets to blank
            always_ff @(posedge px_clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PX_LAT; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else if (en) begin
                    r_pipe[0] <= w_dec;
                    for (int i = 1; i < PX_LAT; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_tail = r_pipe[PX_LAT-1];
        end
    endgenerate

    // Output register: strobes are re-evaluated every cycle so they never stretch
    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            r_rgb <= '0;
            r_de  <= 1'b0;
            r_hs  <= HS_IDLE;
            r_vs  <= VS_IDLE;
            r_ls  <= 1'b0;
            r_fs  <= 1'b0;
        end else begin
            r_ls <= en & w_tail.org_h;
            r_fs <= en & w_tail.org_f;
            if (en) begin
                r_de  <= w_tail.act;
                r_rgb <= w_tail.act ? px_data : '0;
                r_hs  <= w_tail.hs_act ? HS_POL : HS_IDLE;
                r_vs  <= w_tail.vs_act ? VS_POL : VS_IDLE;
            end
        end
    end

    assign {RED, GRN, BLU} = r_rgb;
    assign HSYNC           = r_hs;
    assign VSYNC           = r_vs;
    assign de              = r_de;
    assign line_start      = r_ls;
    assign frame_start     = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: four timing configurations run side by side against a raster model
// that derives every output from the en-cycle index with plain arithmetic.
module tb_vga_timing_gen;

    localparam int NCFG = 4;
    localparam int CW   = 4;
    localparam int DW   = 3 * CW;
    localparam int OW   = 1 + DW + 4;
    localparam int EW   = 11 + 11 + 1 + OW;

    localparam int C_HD  [NCFG] = '{640, 8, 5, 6};
    localparam int C_HF  [NCFG] = '{16, 2, 1, 1};
    localparam int C_HW  [NCFG] = '{96, 3, 2, 1};
    localparam int C_HB  [NCFG] = '{48, 1, 2, 1};
    localparam int C_VD  [NCFG] = '{480, 4, 3, 2};
    localparam int C_VF  [NCFG] = '{10, 1, 1, 1};
    localparam int C_VW  [NCFG] = '{2, 1, 2, 1};
    localparam int C_VB  [NCFG] = '{33, 1, 1, 1};
    localparam bit C_HP  [NCFG] = '{1'b0, 1'b1, 1'b0, 1'b1};
    localparam bit C_VP  [NCFG] = '{1'b0, 1'b1, 1'b0, 1'b0};
    localparam int C_LAT [NCFG] = '{2, 0, 4, 1};

    logic          px_clk = 1'b0;
    logic          rst    = 1'b1;
    logic          en     = 1'b0;
    logic [DW-1:0] px_data [NCFG];
    logic [EW-1:0] w_obs   [NCFG];

    int n_pass  = 0;
    int n_total = 0;

    int                   k    [NCFG];
    logic [OW-1:0]        held [NCFG];
    logic [NCFG*EW-1:0]   exp_q [$];

    always #5 px_clk = ~px_clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        logic [10:0]   ph;
        logic [10:0]   pv;
        logic          preq;
        logic [CW-1:0] r;
        logic [CW-1:0] gr;
        logic [CW-1:0] b;
        logic          hs;
        logic          vs;
        logic          de_o;
        logic          ls;
        logic          fs;

        vga_timing_gen #(
            .H_DATA(C_HD[g]), .H_FP(C_HF[g]), .H_PW(C_HW[g]), .H_BP(C_HB[g]),
            .V_DATA(C_VD[g]), .V_FP(C_VF[g]), .V_PW(C_VW[g]), .V_BP(C_VB[g]),
            .HS_POL(C_HP[g]), .VS_POL(C_VP[g]), .PX_LAT(C_LAT[g]), .COLOR_W(CW)
        ) u_dut (
            .px_clk(px_clk), .rst(rst), .en(en), .px_data(px_data[g]),
            .px_h(ph), .px_v(pv), .px_req(preq),
            .RED(r), .GRN(gr), .BLU(b), .HSYNC(hs), .VSYNC(vs), .de(de_o),
            .line_start(ls), .frame_start(fs)
        );

        assign w_obs[g] = {ph, pv, preq, de_o, r, gr, b, hs, vs, ls, fs};
    end

    function automatic int ht(int i);
        return C_HD[i] + C_HF[i] + C_HW[i] + C_HB[i];
    endfunction

    function automatic int vt(int i);
        return C_VD[i] + C_VF[i] + C_VW[i] + C_VB[i];
    endfunction

    function automatic logic [OW-1:0] blank_out(int i);
        return {1'b0, 12'd0, ~C_HP[i], ~C_VP[i], 1'b0, 1'b0};
    endfunction

    // Output expected for raster position c (pixel index since frame origin)
    function automatic logic [OW-1:0] out_of(int i, int c, logic [DW-1:0] pd);
        int   h;
        int   v;
        logic a;
        logic hsa;
        logic vsa;
        h   = c % ht(i);
        v   = (c / ht(i)) % vt(i);
        a   = (h < C_HD[i]) && (v < C_VD[i]);
        hsa = (h >= C_HD[i] + C_HF[i]) && (h < C_HD[i] + C_HF[i] + C_HW[i]);
        vsa = (v >= C_VD[i] + C_VF[i]) && (v < C_VD[i] + C_VF[i] + C_VW[i]);
        return {a, (a ? pd : 12'd0), (hsa ? C_HP[i] : ~C_HP[i]),
                (vsa ? C_VP[i] : ~C_VP[i]), (h == 0), ((h == 0) && (v == 0))};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCFG; i++) begin
            k[i]    = 0;
            held[i] = blank_out(i);
        end
    endtask

    // Drive one cycle of inputs and push what the next edge must produce
    task automatic step(int mode, int n);
        logic [NCFG*EW-1:0] e;
        logic [OW-1:0]      o;
        int                 c;
        int                 h;
        int                 v;
        logic               req;
        @(negedge px_clk);
        case (mode)
            0:       en = 1'b1;
            1:       en = (n % 4 == 0);
            default: en = 1'($urandom_range(0, 1));
        endcase
        for (int i = 0; i < NCFG; i++) begin
            px_data[i] = DW'($urandom);
        end
        e = '0;
        for (int i = 0; i < NCFG; i++) begin
            if (en) begin
                c = k[i] - C_LAT[i];
                o = (c < 0) ? blank_out(i) : out_of(i, c, px_data[i]);
                k[i]++;
            end else begin
                o = {held[i][OW-1:2], 2'b00};
            end
            held[i] = o;
            h   = k[i] % ht(i);
            v   = (k[i] / ht(i)) % vt(i);
            req = en && (h < C_HD[i]) && (v < C_VD[i]);
            e[i*EW +: EW] = {11'(h), 11'(v), req, o};
        end
        exp_q.push_back(e);
    endtask

    task automatic chk(int i, logic [EW-1:0] obs, logic [EW-1:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL cfg%0d t=%0t {h,v,req,de,rgb,hs,vs,ls,fs} got=%h want=%h",
                     i, $time, obs, exp);
        end
    endtask

    // Monitor: reset values while rst is high, otherwise one scoreboard entry per edge
    initial begin
        logic [NCFG*EW-1:0] e;
        forever begin
            @(posedge px_clk or posedge rst);
            #1;
            if (rst) begin
                for (int i = 0; i < NCFG; i++) begin
                    chk(i, w_obs[i], {22'd0, en, blank_out(i)});
                end
            end else if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL scoreboard t=%0t got=empty-queue want=entry", $time);
            end else begin
                e = exp_q.pop_front();
                for (int i = 0; i < NCFG; i++) begin
                    chk(i, w_obs[i], e[i*EW +: EW]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NCFG; i++) begin
            px_data[i] = '0;
        end
        model_reset();
        repeat (3) @(posedge px_clk);
        #4 rst = 1'b0;
        for (int n = 0; n < 2000; n++) step(0, n);
        for (int n = 0; n < 2000; n++) step(1, n);
        for (int n = 0; n < 2000; n++) step(2, n);
        // Reset mid-cycle, away from any clock edge, to expose its asynchronous effect
        @(posedge px_clk);
        #3 rst = 1'b1;
        repeat (2) @(posedge px_clk);
        #4 rst = 1'b0;
        model_reset();
        for (int n = 0; n < 1500; n++) step(0, n);
        @(posedge px_clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
